// File: rtl/hsv_pipe_ctrl.sv
// hsv_pipe_ctrl: valid/sof/last sequencer, bank enables and frame stats for RGB2HSV.
// Optional feature macro: HSV_PIPE_BUBBLE_COLLAPSE_EN (empty banks load during a stall).
module hsv_pipe_ctrl #(
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_last,
    output logic [STAGES-1:0] stage_en,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_len,
    output logic [7:0]        drop_cnt,
    output logic              err_sof
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] sof_q, sof_d;
    logic [STAGES-1:0] last_q, last_d;

    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        err_sof_q, err_sof_d;

    logic [STAGES-1:0] en_raw;
    logic              adv_out;
    logic              s_acc;
    logic              enter;
    logic              ld0;
    logic              m_hs;

    assign adv_out = !vld_q[STAGES-1] | m_ready;

`ifdef HSV_PIPE_BUBBLE_COLLAPSE_EN
    logic en_acc;

    // Enable ripples back from the output: an empty bank may always load.
    always_comb begin
        en_raw = '0;
        en_acc = adv_out;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (i != STAGES - 1) begin
                en_acc = !vld_q[i] | en_acc;
            end
            en_raw[i] = en_acc;
        end
    end
`else
    assign en_raw = {STAGES{adv_out}};
`endif

    assign stage_en = rst ? '0 : en_raw;
    assign s_ready  = !rst & (state_q != DRAIN) & en_raw[0];
    assign s_acc    = s_valid & s_ready;
    assign enter    = (state_q != IDLE) | s_sof;
    assign ld0      = s_acc & enter;
    assign m_hs     = vld_q[STAGES-1] & m_ready;

    assign m_valid    = vld_q[STAGES-1];
    assign m_sof      = sof_q[STAGES-1];
    assign m_last     = last_q[STAGES-1];
    assign busy       = (state_q != IDLE) | (|vld_q);
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign drop_cnt   = drop_cnt_q;
    assign err_sof    = err_sof_q;

    // Tag shift: each enabled bank copies its upstream neighbour.
    always_comb begin
        vld_d  = vld_q;
        sof_d  = sof_q;
        last_d = last_q;
        if (en_raw[0]) begin
            vld_d[0]  = ld0;
            sof_d[0]  = ld0 & s_sof;
            last_d[0] = ld0 & s_last;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (en_raw[i]) begin
                vld_d[i]  = vld_q[i-1];
                sof_d[i]  = sof_q[i-1];
                last_d[i] = last_q[i-1];
            end
        end
    end

    // Frame FSM, drop counting and mid-frame sof detection.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        err_sof_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_acc) begin
                    if (s_sof) begin
                        state_d = s_last ? DRAIN : RUN;
                    end else if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
            RUN: begin
                if (s_acc) begin
                    err_sof_d = s_sof;
                    if (s_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_hs & last_q[STAGES-1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output-side beat counting; length latched on the last beat.
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        if (m_hs) begin
            pix_cnt_d = sof_q[STAGES-1] ? 16'd1 : pix_cnt_q + 16'd1;
            if (last_q[STAGES-1]) begin
                frame_len_d  = pix_cnt_d;
                frame_done_d = 1'b1;
            end
        end
    end

    // State registers; reset drops all in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vld_q        <= '0;
            sof_q        <= '0;
            last_q       <= '0;
            pix_cnt_q    <= '0;
            frame_len_q  <= '0;
            drop_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            sof_q        <= sof_d;
            last_q       <= last_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_len_q  <= frame_len_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

endmodule

// File: tb/tb_hsv_pipe_ctrl.sv
// tb_hsv_pipe_ctrl: directed + random stimulus against a transaction-level model.
// Honours HSV_PIPE_BUBBLE_COLLAPSE_EN for the stall-mode expectations.
module tb_hsv_pipe_ctrl;

    localparam int S = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
`ifdef HSV_PIPE_BUBBLE_COLLAPSE_EN
    localparam bit COLLAPSE = 1'b1;
`else
    localparam bit COLLAPSE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_sof = 1'b0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b0;
    logic         s_ready;
    logic         m_valid;
    logic         m_sof;
    logic         m_last;
    logic [S-1:0] stage_en;
    logic         busy;
    logic         frame_done;
    logic [15:0]  frame_len;
    logic [7:0]   drop_cnt;
    logic         err_sof;

    hsv_pipe_ctrl #(.STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sof      (m_sof),
        .m_last     (m_last),
        .stage_en   (stage_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .drop_cnt   (drop_cnt),
        .err_sof    (err_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sof;
        bit last;
        int t;
    } beat_t;

    beat_t q[$];
    int    mmode = M_IDLE;
    int    exp_drop = 0;
    int    exp_len = 0;
    int    pix = 0;
    bit    exp_fd = 0;
    bit    exp_err = 0;
    int    cyc = 0;
    bit    lat_chk = 0;
    bit    prev_stall = 0;
    logic  prev_sof = 0;
    logic  prev_last = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mmode    = M_IDLE;
        exp_drop = 0;
        exp_len  = 0;
        pix      = 0;
        exp_fd   = 0;
        exp_err  = 0;
        prev_stall = 0;
    endtask

    task automatic step(input bit v, input bit sof, input bit last,
                        input bit mr, input bit rs);
        bit stalled, exp_rdy, acc, hs;
        logic [S-1:0] exp_en;
        beat_t b;
        @(negedge clk);
        rst = rs;
        s_valid = v;
        s_sof = sof;
        s_last = last;
        m_ready = mr;
        #1;
        cyc++;
        chk("frame_done", frame_done, exp_fd);
        chk("err_sof", err_sof, exp_err);
        chk("drop_cnt", drop_cnt, exp_drop);
        chk("frame_len", frame_len, exp_len);
        chk("busy", busy, (mmode != M_IDLE) || (q.size() != 0));
        if (q.size() == 0) chk("m_valid_empty", m_valid, 0);
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_sof", m_sof, prev_sof);
            chk("hold_last", m_last, prev_last);
        end
        if (rs) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_stage_en", stage_en, 0);
            model_reset();
            return;
        end
        stalled = m_valid && !m_ready;
        exp_rdy = (mmode != M_DRAIN) && (!stalled || (COLLAPSE && q.size() < S));
        chk("s_ready", s_ready, exp_rdy);
        if (COLLAPSE) begin
            chk("stage_en_top", stage_en[S-1], !stalled);
        end else begin
            exp_en = stalled ? '0 : '1;
            chk("stage_en", stage_en, exp_en);
        end
        acc = s_valid && s_ready;
        hs  = m_valid && m_ready;
        exp_fd  = 0;
        exp_err = 0;
        if (acc) begin
            if (mmode == M_IDLE) begin
                if (sof) begin
                    q.push_back('{sof, last, cyc});
                    mmode = last ? M_DRAIN : M_RUN;
                end else if (exp_drop < 255) begin
                    exp_drop++;
                end
            end else begin
                q.push_back('{sof, last, cyc});
                if (sof) exp_err = 1;
                if (last) mmode = M_DRAIN;
            end
        end
        if (hs && q.size() != 0) begin
            b = q.pop_front();
            chk("m_sof", m_sof, b.sof);
            chk("m_last", m_last, b.last);
            if (lat_chk) chk("latency", cyc - b.t, S);
            pix = b.sof ? 1 : (pix + 1) % 65536;
            if (b.last) begin
                exp_len = pix;
                exp_fd  = 1;
                mmode   = M_IDLE;
            end
        end
        prev_stall = stalled;
        prev_sof   = m_sof;
        prev_last  = m_last;
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) step(0, 0, 0, mr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        step(0, 0, 0, 1, 1);
        idle(3, 1);

        // Five-beat frame, no stall: latency and frame_len.
        lat_chk = 1;
        for (int i = 0; i < 5; i++) step(1, i == 0, i == 4, 1, 0);
        idle(6, 1);
        chk("frame_len_5", frame_len, 5);
        lat_chk = 0;

        // Beats without sof in IDLE are dropped, count saturates.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        idle(6, 1);
        chk("drop_3", drop_cnt, 3);
        for (int i = 0; i < 300; i++) step(1, 0, i[0], 1, 0);
        idle(1, 1);
        chk("drop_sat", drop_cnt, 255);

        // Two beats separated by bubbles, then a 6-cycle output stall.
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        idle(1, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
        idle(10, 1);

        // Second sof mid-frame restarts the count.
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        idle(8, 1);
        chk("frame_len_restart", frame_len, 3);

        // Reset with three beats in flight.
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        idle(6, 1);

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 499) == 0);
        end
        idle(20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
